// File: rtl/program_loader.sv
// Framed byte-stream loader for the core's 256x8 instruction RAM; holds the core until a checksummed frame is stored.
// Optional PROGRAM_LOADER_ECHO_EN echoes every accepted byte back to the host one cycle later.
module program_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] echo_data,
  output logic              echo_valid
);

  typedef enum logic [2:0] {S_LEN, S_DATA, S_CHECK, S_RUN, S_ERR} state_t;

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);

  state_t            state;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   len;
  logic [DATA_W-1:0] xor_acc;
  logic [DATA_W-1:0] mem [0:2**ADDR_W-1];
  logic              xfer;
  logic [ADDR_W:0]   len_in;

  assign in_ready = (state == S_LEN) || (state == S_DATA) || (state == S_CHECK);
  // reload wins over a same-cycle transfer, so the byte is simply dropped
  assign xfer     = in_valid && in_ready && !reload;
  assign len_in   = (in_data == '0) ? DEPTH : (ADDR_W+1)'(in_data);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_LEN;
      count    <= '0;
      len      <= '0;
      xor_acc  <= '0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
    end else if (reload) begin
      state    <= S_LEN;
      count    <= '0;
      len      <= '0;
      xor_acc  <= '0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
    end else if (xfer) begin
      case (state)
        S_LEN: begin
          len     <= len_in;
          count   <= '0;
          xor_acc <= '0;
          state   <= S_DATA;
        end
        S_DATA: begin
          xor_acc <= xor_acc ^ in_data;
          count   <= count + 1'b1;
          if (count == len - 1'b1) state <= S_CHECK;
        end
        S_CHECK: begin
          if (in_data == xor_acc) begin
            state    <= S_RUN;
            cpu_hold <= 1'b0;
            done     <= 1'b1;
            err      <= 1'b0;
          end else begin
            state    <= S_ERR;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b1;
          end
        end
        default: state <= state;
      endcase
    end
  end

  // RAM has no reset; only the address low bits are used, so the 256-byte frame ends at 255
  always_ff @(posedge clk) begin
    if (rst_n && xfer && state == S_DATA)
      mem[count[ADDR_W-1:0]] <= in_data;
  end

  assign fetch_instr = (state == S_RUN && {1'b0, fetch_addr} < len) ? mem[fetch_addr] : '0;

`ifdef PROGRAM_LOADER_ECHO_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      echo_valid <= 1'b0;
      echo_data  <= '0;
    end else begin
      echo_valid <= xfer;
      if (xfer) echo_data <= in_data;
    end
  end
`else
  assign echo_valid = 1'b0;
  assign echo_data  = '0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus queues expectations, a negedge monitor pops and compares.
module tb_program_loader;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              reload;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_instr;
  logic              cpu_hold;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] echo_data;
  logic              echo_valid;

  program_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .reload(reload), .fetch_addr(fetch_addr),
    .fetch_instr(fetch_instr), .cpu_hold(cpu_hold), .done(done), .err(err),
    .echo_data(echo_data), .echo_valid(echo_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 = fetch_instr, 1 = {cpu_hold,done,err,in_ready}, 2 = echo outputs idle
  typedef struct {
    string      name;
    int         kind;
    logic [7:0] exp;
  } probe_t;

  probe_t     probe_q[$];
  logic [3:0] stat_q[$];
  string      stat_name_q[$];
  logic [7:0] echo_q[$];
  int         tests = 0;
  int         fails = 0;

  logic [3:0] prev_stat = 4'bxxxx;
  logic [3:0] stat_now;
  probe_t     p;
  logic [3:0] se;
  string      sn;
  logic [7:0] ee;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    stat_now = {cpu_hold, done, err, in_ready};
    if (rst_n && !$isunknown(prev_stat) && stat_now !== prev_stat) begin
      if (stat_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_status: got %b expected no change from %b", stat_now, prev_stat);
      end else begin
        se = stat_q.pop_front();
        sn = stat_name_q.pop_front();
        check(sn, {4'b0, stat_now}, {4'b0, se});
      end
    end
    prev_stat = stat_now;
    if (probe_q.size() > 0) begin
      p = probe_q.pop_front();
      case (p.kind)
        0: check(p.name, fetch_instr, p.exp);
        1: check(p.name, {4'b0, stat_now}, p.exp);
        default: begin
          check({p.name, "_valid"}, {7'b0, echo_valid}, 8'h00);
          check({p.name, "_data"}, echo_data, 8'h00);
        end
      endcase
    end
    if (echo_valid === 1'b1) begin
`ifdef PROGRAM_LOADER_ECHO_EN
      if (echo_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL echo_unexpected: got %h expected no echo", echo_data);
      end else begin
        ee = echo_q.pop_front();
        check("echo", echo_data, ee);
      end
`else
      tests++;
      fails++;
      $display("FAIL echo_disabled: got echo_valid 1 data %h expected 0", echo_data);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    bit acc = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready 0 for %0d cycles expected 1 (byte %h)", n, b);
    end else begin
`ifdef PROGRAM_LOADER_ECHO_EN
      echo_q.push_back(b);
`endif
    end
  endtask

  task automatic expect_stat(input logic [3:0] v, input string name);
    stat_q.push_back(v);
    stat_name_q.push_back(name);
  endtask

  task automatic probe_fetch(input logic [7:0] a, input logic [7:0] e, input string name);
    probe_t q;
    fetch_addr = a;
    q = '{name, 0, e};
    probe_q.push_back(q);
    tick();
  endtask

  task automatic probe_stat(input logic [3:0] e, input string name);
    probe_t q;
    q = '{name, 1, {4'b0, e}};
    probe_q.push_back(q);
    tick();
  endtask

  task automatic do_reload(input string name);
    expect_stat(4'b1001, name);
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; reload = 1'b0; in_data = '0; fetch_addr = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    probe_stat(4'b1001, "reset_status");
    probe_fetch(8'h00, 8'h00, "reset_fetch");

    // good 3-byte frame
    send(8'h03); send(8'h12); send(8'h34); send(8'h56);
    expect_stat(4'b0100, "good_chk");
    send(8'h70);
    probe_fetch(8'h00, 8'h12, "f3_addr0");
    probe_fetch(8'h01, 8'h34, "f3_addr1");
    probe_fetch(8'h02, 8'h56, "f3_addr2");
    probe_fetch(8'h03, 8'h00, "f3_addr3");
    do_reload("reload_run");

    // bad checksum
    send(8'h03); send(8'h12); send(8'h34); send(8'h56);
    expect_stat(4'b1010, "bad_chk");
    send(8'h71);
    probe_fetch(8'h00, 8'h00, "err_fetch0");
    probe_stat(4'b1010, "err_hold");
    do_reload("reload_err");

    // full 256-byte frame
    send(8'h00);
    for (int i = 0; i < 256; i++) send(8'(i));
    expect_stat(4'b0100, "f256_chk");
    send(8'h00);
    probe_fetch(8'hFF, 8'hFF, "f256_addrFF");
    probe_fetch(8'h80, 8'h80, "f256_addr80");
    probe_fetch(8'h7F, 8'h7F, "f256_addr7F");
    do_reload("reload_256");

    // handshake stall between payload bytes
    send(8'h02); send(8'hAB);
    in_data = 8'hFF; in_valid = 1'b0;
    tick();
    send(8'hCD);
    expect_stat(4'b0100, "stall_chk");
    send(8'h66);
    probe_fetch(8'h00, 8'hAB, "stall_addr0");
    probe_fetch(8'h01, 8'hCD, "stall_addr1");
    probe_fetch(8'h02, 8'h00, "stall_addr2");
    do_reload("reload_stall");

    // reload with a concurrent transfer discards the byte
    send(8'h03); send(8'h11);
    in_data = 8'h22; in_valid = 1'b1; reload = 1'b1;
    tick();
    reload = 1'b0; in_valid = 1'b0;
    send(8'h02); send(8'hAA); send(8'h55);
    expect_stat(4'b0100, "abort_chk");
    send(8'hFF);
    probe_fetch(8'h00, 8'hAA, "abort_addr0");
    probe_fetch(8'h01, 8'h55, "abort_addr1");
    probe_fetch(8'h02, 8'h00, "abort_addr2");
    do_reload("reload_abort");

    // reset mid-frame
    send(8'h04); send(8'h01); send(8'h02);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    probe_stat(4'b1001, "midrst_status");
    probe_fetch(8'h00, 8'h00, "midrst_fetch");
    send(8'h01); send(8'h5A);
    expect_stat(4'b0100, "midrst_chk");
    send(8'h5A);
    probe_fetch(8'h00, 8'h5A, "midrst_addr0");
    probe_fetch(8'h01, 8'h00, "midrst_addr1");

`ifndef PROGRAM_LOADER_ECHO_EN
    begin
      probe_t q;
      q = '{"echo_idle", 2, 8'h00};
      probe_q.push_back(q);
      tick();
    end
`endif

    n = 0;
    while ((probe_q.size() != 0 || stat_q.size() != 0 || echo_q.size() != 0) && n < 50) begin
      tick();
      n++;
    end
    tick();
    if (probe_q.size() != 0 || stat_q.size() != 0 || echo_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d/%0d/%0d pending expected 0/0/0",
               probe_q.size(), stat_q.size(), echo_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
